// File: rtl/idma_legalizer_burst_credit_pkg.sv
// Shared constants and helpers for the burst-credit legalizer.
package idma_legalizer_burst_credit_pkg;

    localparam int unsigned LlenWidth = 3;

    // Bit width able to index n values; never below one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/idma_legalizer_burst_limit.sv
// Bytes one burst may cover from addr before hitting a page, beat-cap or reduced-length boundary.
module idma_legalizer_burst_limit
    import idma_legalizer_burst_credit_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned LenWidth  = 32,
    parameter int unsigned StrbWidth = 8,
    parameter int unsigned PageSize  = 4096,
    parameter int unsigned MaxBeats  = 256
) (
    input  logic [AddrWidth-1:0] addr,
    input  logic                 reduce,
    input  logic [LlenWidth-1:0] llen,
    output logic [LenWidth-1:0]  possible
);

    localparam int unsigned CapBytes = MaxBeats * StrbWidth;

    logic [LenWidth-1:0] addr_l;
    logic [LenWidth-1:0] to_page;
    logic [LenWidth-1:0] to_cap;
    logic [LenWidth-1:0] red_size;
    logic [LenWidth-1:0] to_red;
    logic [LenWidth-1:0] lim;

    always_comb begin
        addr_l   = LenWidth'(addr);
        to_page  = LenWidth'(PageSize) - (addr_l & LenWidth'(PageSize - 1));
        to_cap   = LenWidth'(CapBytes) - (addr_l & LenWidth'(CapBytes - 1));
        red_size = LenWidth'(StrbWidth) << llen;
        to_red   = red_size - (addr_l & (red_size - LenWidth'(1)));
        lim      = (to_page < to_cap) ? to_page : to_cap;
        if (reduce && (to_red < lim)) begin
            lim = to_red;
        end
        possible = lim;
    end

endmodule

// File: rtl/idma_legalizer_burst_credit.sv
// Splits a 1D transfer into page/cap-legal read and write bursts, with a write-side
// outstanding-burst credit counter.
module idma_legalizer_burst_credit
    import idma_legalizer_burst_credit_pkg::*;
#(
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned LenWidth       = 32,
    parameter int unsigned PageSize       = 4096,
    parameter int unsigned MaxBeats       = 256,
    parameter int unsigned MaxOutstanding = 8,
    localparam int unsigned StrbWidth     = DataWidth / 8,
    localparam int unsigned OffsetWidth   = $clog2(StrbWidth),
    localparam int unsigned BeatsWidth    = width_of(MaxBeats),
    localparam int unsigned CntWidth      = width_of(MaxOutstanding + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [AddrWidth-1:0]   req_src_addr_i,
    input  logic [AddrWidth-1:0]   req_dst_addr_i,
    input  logic [LenWidth-1:0]    req_length_i,
    input  logic                   req_decouple_i,
    input  logic                   req_src_reduce_len_i,
    input  logic                   req_dst_reduce_len_i,
    input  logic [LlenWidth-1:0]   req_src_max_llen_i,
    input  logic [LlenWidth-1:0]   req_dst_max_llen_i,
    output logic                   r_valid_o,
    input  logic                   r_ready_i,
    output logic [AddrWidth-1:0]   r_addr_o,
    output logic [BeatsWidth-1:0]  r_beats_o,
    output logic [OffsetWidth-1:0] r_offset_o,
    output logic [OffsetWidth-1:0] r_tailer_o,
    output logic                   r_last_o,
    output logic                   w_valid_o,
    input  logic                   w_ready_i,
    output logic [AddrWidth-1:0]   w_addr_o,
    output logic [BeatsWidth-1:0]  w_beats_o,
    output logic [OffsetWidth-1:0] w_offset_o,
    output logic [OffsetWidth-1:0] w_tailer_o,
    output logic                   w_last_o,
    input  logic                   w_done_i,
    input  logic                   flush_i,
    input  logic                   kill_i,
    output logic                   r_busy_o,
    output logic                   w_busy_o,
    output logic [CntWidth-1:0]    outstanding_o
);

    typedef struct packed {
        logic                 valid;
        logic [AddrWidth-1:0] addr;
        logic [LenWidth-1:0]  len;
    } side_t;

    typedef struct packed {
        logic                 decouple;
        logic                 src_reduce;
        logic [LlenWidth-1:0] src_llen;
        logic                 dst_reduce;
        logic [LlenWidth-1:0] dst_llen;
    } opt_t;

    typedef struct packed {
        logic [AddrWidth-1:0]   addr;
        logic [BeatsWidth-1:0]  beats;
        logic [OffsetWidth-1:0] offset;
        logic [OffsetWidth-1:0] tailer;
        logic                   last;
    } burst_t;

    side_t r_st, r_st_next, w_st, w_st_next;
    opt_t opt, opt_next;
    logic [CntWidth-1:0] outstanding, outstanding_next;
    logic [LenWidth-1:0] r_pos, w_pos, r_lim, w_lim, r_bytes, w_bytes;
    burst_t r_burst, w_burst;
    logic credit_ok, joint, r_fire, w_fire, accept, dec;

    // Idle sides present all-zero fields.
    function automatic burst_t make_burst(input side_t s, input logic [LenWidth-1:0] bytes,
                                          input logic last);
        logic [LenWidth-1:0] span;
        burst_t b;
        b    = '0;
        span = bytes + LenWidth'(s.addr[OffsetWidth-1:0]);
        if (s.valid) begin
            b.addr   = {s.addr[AddrWidth-1:OffsetWidth], {OffsetWidth{1'b0}}};
            b.beats  = BeatsWidth'((span - LenWidth'(1)) >> OffsetWidth);
            b.offset = s.addr[OffsetWidth-1:0];
            b.tailer = span[OffsetWidth-1:0];
            b.last   = last;
        end
        return b;
    endfunction

    idma_legalizer_burst_limit #(
        .AddrWidth (AddrWidth),
        .LenWidth  (LenWidth),
        .StrbWidth (StrbWidth),
        .PageSize  (PageSize),
        .MaxBeats  (MaxBeats)
    ) u_r_limit (
        .addr     (r_st.addr),
        .reduce   (opt.src_reduce),
        .llen     (opt.src_llen),
        .possible (r_pos)
    );

    idma_legalizer_burst_limit #(
        .AddrWidth (AddrWidth),
        .LenWidth  (LenWidth),
        .StrbWidth (StrbWidth),
        .PageSize  (PageSize),
        .MaxBeats  (MaxBeats)
    ) u_w_limit (
        .addr     (w_st.addr),
        .reduce   (opt.dst_reduce),
        .llen     (opt.dst_llen),
        .possible (w_pos)
    );

    always_comb begin
        r_lim   = (opt.decouple || (r_pos < w_pos)) ? r_pos : w_pos;
        w_lim   = (opt.decouple || (w_pos < r_pos)) ? w_pos : r_pos;
        r_bytes = (r_st.len < r_lim) ? r_st.len : r_lim;
        w_bytes = (w_st.len < w_lim) ? w_st.len : w_lim;
        r_burst = make_burst(r_st, r_bytes, r_st.len <= r_lim);
        w_burst = make_burst(w_st, w_bytes, w_st.len <= w_lim);

        credit_ok = outstanding < CntWidth'(MaxOutstanding);
        joint     = r_st.valid & w_st.valid & !flush_i & !kill_i & credit_ok;
        if (opt.decouple) begin
            r_valid_o = r_st.valid & !flush_i & !kill_i;
            w_valid_o = w_st.valid & !flush_i & !kill_i & credit_ok;
        end else begin
            // Coupled sides only advance together, so each valid waits on the other's ready.
            r_valid_o = joint & w_ready_i;
            w_valid_o = joint & r_ready_i;
        end
        r_fire = r_valid_o & r_ready_i;
        w_fire = w_valid_o & w_ready_i;

        req_ready_o = (((!r_st.valid | (r_fire & r_burst.last)) &
                        (!w_st.valid | (w_fire & w_burst.last))) | kill_i) & !flush_i;
        accept = req_valid_i & req_ready_o;

        r_st_next = r_st;
        w_st_next = w_st;
        opt_next  = opt;
        if (r_fire) begin
            r_st_next.addr  = r_st.addr + AddrWidth'(r_bytes);
            r_st_next.len   = r_st.len - r_bytes;
            r_st_next.valid = !r_burst.last;
        end
        if (w_fire) begin
            w_st_next.addr  = w_st.addr + AddrWidth'(w_bytes);
            w_st_next.len   = w_st.len - w_bytes;
            w_st_next.valid = !w_burst.last;
        end
        if (kill_i) begin
            r_st_next = '0;
            w_st_next = '0;
        end
        if (accept) begin
            r_st_next = '{valid: 1'b1, addr: req_src_addr_i, len: req_length_i};
            w_st_next = '{valid: 1'b1, addr: req_dst_addr_i, len: req_length_i};
            opt_next  = '{decouple: req_decouple_i,
                          src_reduce: req_src_reduce_len_i, src_llen: req_src_max_llen_i,
                          dst_reduce: req_dst_reduce_len_i, dst_llen: req_dst_max_llen_i};
        end

        // A spurious done at zero is dropped rather than wrapping the counter.
        dec = w_done_i & (outstanding != '0);
        outstanding_next = outstanding;
        if (w_fire && !dec) begin
            outstanding_next = outstanding + CntWidth'(1);
        end else if (!w_fire && dec) begin
            outstanding_next = outstanding - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_st        <= '0;
            w_st        <= '0;
            opt         <= '0;
            outstanding <= '0;
        end else begin
            r_st        <= r_st_next;
            w_st        <= w_st_next;
            opt         <= opt_next;
            outstanding <= outstanding_next;
        end
    end

    assign r_addr_o      = r_burst.addr;
    assign r_beats_o     = r_burst.beats;
    assign r_offset_o    = r_burst.offset;
    assign r_tailer_o    = r_burst.tailer;
    assign r_last_o      = r_burst.last;
    assign w_addr_o      = w_burst.addr;
    assign w_beats_o     = w_burst.beats;
    assign w_offset_o    = w_burst.offset;
    assign w_tailer_o    = w_burst.tailer;
    assign w_last_o      = w_burst.last;
    assign r_busy_o      = r_st.valid;
    assign w_busy_o      = w_st.valid;
    assign outstanding_o = outstanding;

    assert property (@(posedge clk_i) disable iff (rst_i) accept |-> (req_length_i != '0));
    assert property (@(posedge clk_i) disable iff (rst_i) w_done_i |-> (outstanding != '0));
    assert property (@(posedge clk_i) disable iff (rst_i)
                     (r_valid_o && !r_ready_i) |=> $stable(r_burst));
    assert property (@(posedge clk_i) disable iff (rst_i)
                     (w_valid_o && !w_ready_i) |=> $stable(w_burst));

endmodule

// File: tb/tb_idma_legalizer_burst_credit.sv
// Directed bench for the burst-credit legalizer: 32-bit data, three write bursts of credit.
module tb_idma_legalizer_burst_credit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_src, req_dst, req_len;
    logic        req_dec, req_sr, req_dr;
    logic [2:0]  req_sl, req_dl;
    logic        r_valid, r_ready, r_last, w_valid, w_ready, w_last;
    logic [31:0] r_addr, w_addr;
    logic [7:0]  r_beats, w_beats;
    logic [1:0]  r_off, r_tail, w_off, w_tail;
    logic        w_done, flush, kill, r_busy, w_busy;
    logic [1:0]  outstanding;

    int total = 0;
    int bad   = 0;

    wire [45:0] r_tup = {r_valid, r_addr, r_beats, r_off, r_tail, r_last};
    wire [45:0] w_tup = {w_valid, w_addr, w_beats, w_off, w_tail, w_last};

    always #5 clk = ~clk;

    idma_legalizer_burst_credit #(
        .DataWidth      (32),
        .AddrWidth      (32),
        .LenWidth       (32),
        .PageSize       (4096),
        .MaxBeats       (256),
        .MaxOutstanding (3)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .req_valid_i          (req_valid),
        .req_ready_o          (req_ready),
        .req_src_addr_i       (req_src),
        .req_dst_addr_i       (req_dst),
        .req_length_i         (req_len),
        .req_decouple_i       (req_dec),
        .req_src_reduce_len_i (req_sr),
        .req_dst_reduce_len_i (req_dr),
        .req_src_max_llen_i   (req_sl),
        .req_dst_max_llen_i   (req_dl),
        .r_valid_o            (r_valid),
        .r_ready_i            (r_ready),
        .r_addr_o             (r_addr),
        .r_beats_o            (r_beats),
        .r_offset_o           (r_off),
        .r_tailer_o           (r_tail),
        .r_last_o             (r_last),
        .w_valid_o            (w_valid),
        .w_ready_i            (w_ready),
        .w_addr_o             (w_addr),
        .w_beats_o            (w_beats),
        .w_offset_o           (w_off),
        .w_tailer_o           (w_tail),
        .w_last_o             (w_last),
        .w_done_i             (w_done),
        .flush_i              (flush),
        .kill_i               (kill),
        .r_busy_o             (r_busy),
        .w_busy_o             (w_busy),
        .outstanding_o        (outstanding)
    );

    task automatic send_req(input logic [31:0] src, input logic [31:0] dst,
                            input logic [31:0] len, input logic dec, input logic dr,
                            input logic [2:0] dl);
        req_src = src; req_dst = dst; req_len = len; req_dec = dec;
        req_sr = 1'b0; req_sl = 3'd0; req_dr = dr; req_dl = dl;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
    endtask

    task automatic drain(input int n);
        w_done = 1'b1;
        repeat (n) @(negedge clk);
        w_done = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({r_valid, w_valid, r_busy, w_busy, outstanding, req_ready} !== 7'b0000_001) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 0000001",
                     {r_valid, w_valid, r_busy, w_busy, outstanding, req_ready});
        end
        total++;
        if ({r_tup, w_tup} !== 92'd0) begin
            bad++;
            $display("FAIL reset_fields: got %h want 0", {r_tup, w_tup});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_coupled();
        r_ready = 1'b1; w_ready = 1'b0;
        send_req(32'hFF2, 32'h2000, 32, 1'b0, 1'b0, 3'd0);
        total++;
        if ({r_valid, w_valid} !== 2'b01) begin
            bad++;
            $display("FAIL coupled_gate: got %b want 01", {r_valid, w_valid});
        end
        w_ready = 1'b1;
        #1;
        total++;
        if (r_tup !== {1'b1, 32'h0FF0, 8'd3, 2'd2, 2'd0, 1'b0}) begin
            bad++;
            $display("FAIL coupled_r0: got %h", r_tup);
        end
        total++;
        if (w_tup !== {1'b1, 32'h2000, 8'd3, 2'd0, 2'd2, 1'b0}) begin
            bad++;
            $display("FAIL coupled_w0: got %h", w_tup);
        end
        @(negedge clk); #1;
        total++;
        if (r_tup !== {1'b1, 32'h1000, 8'd4, 2'd0, 2'd2, 1'b1}) begin
            bad++;
            $display("FAIL coupled_r1: got %h", r_tup);
        end
        total++;
        if (w_tup !== {1'b1, 32'h200C, 8'd4, 2'd2, 2'd0, 1'b1}) begin
            bad++;
            $display("FAIL coupled_w1: got %h", w_tup);
        end
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL coupled_b2b_ready: got %b want 1", req_ready);
        end
        @(negedge clk); #1;
        total++;
        if ({r_busy, w_busy, outstanding} !== 4'b0010) begin
            bad++;
            $display("FAIL coupled_end: got %b want 0010", {r_busy, w_busy, outstanding});
        end
        drain(2);
        total++;
        if (outstanding !== 2'd0) begin
            bad++;
            $display("FAIL coupled_drain: got %0d want 0", outstanding);
        end
    endtask

    task automatic test_decoupled();
        r_ready = 1'b0; w_ready = 1'b1;
        send_req(32'hFF2, 32'h2000, 32, 1'b1, 1'b0, 3'd0);
        total++;
        if (w_tup !== {1'b1, 32'h2000, 8'd7, 2'd0, 2'd0, 1'b1}) begin
            bad++;
            $display("FAIL decoupled_w: got %h", w_tup);
        end
        total++;
        if (r_tup !== {1'b1, 32'h0FF0, 8'd3, 2'd2, 2'd0, 1'b0}) begin
            bad++;
            $display("FAIL decoupled_r0: got %h", r_tup);
        end
        @(negedge clk); #1;
        total++;
        if ({w_busy, w_valid, outstanding, r_busy} !== 5'b00011) begin
            bad++;
            $display("FAIL decoupled_w_alone: got %b want 00011",
                     {w_busy, w_valid, outstanding, r_busy});
        end
        r_ready = 1'b1;
        @(negedge clk); #1;
        total++;
        if (r_tup !== {1'b1, 32'h1000, 8'd4, 2'd0, 2'd2, 1'b1}) begin
            bad++;
            $display("FAIL decoupled_r1: got %h", r_tup);
        end
        @(negedge clk); #1;
        total++;
        if (r_busy !== 1'b0) begin
            bad++;
            $display("FAIL decoupled_r_done: got %b want 0", r_busy);
        end
        drain(1);
    endtask

    task automatic test_reduce();
        r_ready = 1'b1; w_ready = 1'b1;
        send_req(32'h0, 32'h2000, 40, 1'b1, 1'b1, 3'd2);
        total++;
        if (r_tup !== {1'b1, 32'h0, 8'd9, 2'd0, 2'd0, 1'b1}) begin
            bad++;
            $display("FAIL reduce_r: got %h", r_tup);
        end
        total++;
        if ({w_tup, req_ready} !== {1'b1, 32'h2000, 8'd3, 2'd0, 2'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reduce_w0: got %h", {w_tup, req_ready});
        end
        @(negedge clk); #1;
        total++;
        if (w_tup !== {1'b1, 32'h2010, 8'd3, 2'd0, 2'd0, 1'b0}) begin
            bad++;
            $display("FAIL reduce_w1: got %h", w_tup);
        end
        @(negedge clk); #1;
        total++;
        if ({w_tup, req_ready} !== {1'b1, 32'h2020, 8'd1, 2'd0, 2'd0, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL reduce_w2: got %h", {w_tup, req_ready});
        end
        @(negedge clk); #1;
        total++;
        if ({w_busy, outstanding} !== 3'b011) begin
            bad++;
            $display("FAIL reduce_end: got %b want 011", {w_busy, outstanding});
        end
        drain(3);
    endtask

    task automatic test_credit();
        r_ready = 1'b1; w_ready = 1'b1;
        send_req(32'h100, 32'h3000, 16, 1'b1, 1'b1, 3'd0);
        total++;
        if (w_tup !== {1'b1, 32'h3000, 8'd0, 2'd0, 2'd0, 1'b0}) begin
            bad++;
            $display("FAIL credit_w0: got %h", w_tup);
        end
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({w_tup, w_busy, outstanding} !==
            {1'b0, 32'h300C, 8'd0, 2'd0, 2'd0, 1'b1, 1'b1, 2'd3}) begin
            bad++;
            $display("FAIL credit_held: got %h", {w_tup, w_busy, outstanding});
        end
        w_done = 1'b1;
        @(negedge clk);
        w_done = 1'b0;
        #1;
        total++;
        if ({w_valid, outstanding} !== 3'b110) begin
            bad++;
            $display("FAIL credit_release: got %b want 110", {w_valid, outstanding});
        end
        @(negedge clk); #1;
        total++;
        if ({w_busy, outstanding} !== 3'b011) begin
            bad++;
            $display("FAIL credit_refill: got %b want 011", {w_busy, outstanding});
        end
        drain(3);
    endtask

    task automatic test_flush();
        r_ready = 1'b1; w_ready = 1'b1;
        send_req(32'h40, 32'h6000, 16, 1'b1, 1'b1, 3'd0);
        @(negedge clk);
        flush = 1'b1; w_done = 1'b1;
        #1;
        total++;
        if ({r_valid, w_valid, req_ready, w_busy} !== 4'b0001) begin
            bad++;
            $display("FAIL flush_gate: got %b want 0001", {r_valid, w_valid, req_ready, w_busy});
        end
        @(negedge clk);
        w_done = 1'b0;
        #1;
        total++;
        if ({w_tup, outstanding} !== {1'b0, 32'h6004, 8'd0, 2'd0, 2'd0, 1'b0, 2'd0}) begin
            bad++;
            $display("FAIL flush_hold: got %h", {w_tup, outstanding});
        end
        flush = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({w_busy, outstanding} !== 3'b011) begin
            bad++;
            $display("FAIL flush_resume: got %b want 011", {w_busy, outstanding});
        end
        drain(3);
    endtask

    task automatic test_kill();
        r_ready = 1'b1; w_ready = 1'b1;
        send_req(32'h0, 32'h4000, 4096, 1'b0, 1'b0, 3'd0);
        total++;
        if ({r_tup, w_tup} !== {1'b1, 32'h0, 8'd255, 2'd0, 2'd0, 1'b0,
                                1'b1, 32'h4000, 8'd255, 2'd0, 2'd0, 1'b0}) begin
            bad++;
            $display("FAIL kill_first: got %h", {r_tup, w_tup});
        end
        @(negedge clk);
        kill = 1'b1;
        #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL kill_ready: got %b want 1", req_ready);
        end
        @(negedge clk);
        kill = 1'b0;
        #1;
        total++;
        if ({r_busy, w_busy, outstanding} !== 4'b0001) begin
            bad++;
            $display("FAIL kill_clear: got %b want 0001", {r_busy, w_busy, outstanding});
        end
        send_req(32'h0, 32'h4000, 4096, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        kill = 1'b1;
        req_src = 32'h10; req_dst = 32'h5000; req_len = 8; req_dec = 1'b0; req_dr = 1'b0;
        req_valid = 1'b1;
        @(negedge clk);
        kill = 1'b0; req_valid = 1'b0;
        #1;
        total++;
        if ({r_tup, w_tup, outstanding} !== {1'b1, 32'h10, 8'd1, 2'd0, 2'd0, 1'b1,
                                             1'b1, 32'h5000, 8'd1, 2'd0, 2'd0, 1'b1,
                                             2'd2}) begin
            bad++;
            $display("FAIL kill_accept: got %h", {r_tup, w_tup, outstanding});
        end
        @(negedge clk); #1;
        total++;
        if ({r_busy, w_busy, outstanding} !== 4'b0011) begin
            bad++;
            $display("FAIL kill_next_done: got %b want 0011", {r_busy, w_busy, outstanding});
        end
        drain(3);
    endtask

    task automatic test_reset_mid();
        r_ready = 1'b1; w_ready = 1'b1;
        send_req(32'h100, 32'h7000, 16, 1'b1, 1'b1, 3'd0);
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({w_busy, outstanding} !== 3'b111) begin
            bad++;
            $display("FAIL rstmid_pre: got %b want 111", {w_busy, outstanding});
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({r_valid, w_valid, r_busy, w_busy, outstanding, req_ready} !== 7'b0000_001) begin
            bad++;
            $display("FAIL rstmid_async: got %b want 0000001",
                     {r_valid, w_valid, r_busy, w_busy, outstanding, req_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_src = '0; req_dst = '0; req_len = '0;
        req_dec = 1'b0; req_sr = 1'b0; req_dr = 1'b0; req_sl = '0; req_dl = '0;
        r_ready = 1'b0; w_ready = 1'b0; w_done = 1'b0; flush = 1'b0; kill = 1'b0;
        test_reset();
        test_coupled();
        test_decoupled();
        test_reduce();
        test_credit();
        test_flush();
        test_kill();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
